// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlp_pkg
// Description : Shared types and constants for the MLP layer scheduler.
//               Holds the scheduler state encoding, the class count, the
//               default image and layer counts, the byte-address shift and
//               the helpers that size the counters and the y_buf word index.
// Revision    : 1.0 - initial release
// ============================================================================
package mlp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LAUNCH     = 3'd1,
        ST_WAIT_LAYER = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_NEXT_IMG   = 3'd4,
        ST_DONE       = 3'd5
    } sched_state_t;

    localparam int NUM_CLASS          = 10;
    localparam int IN_IMG_NUM_DEFAULT = 10;
    localparam int NUM_LAYERS_DEFAULT = 3;
    // y_buf is byte addressed with 32-bit words: word index << 2
    localparam int ADDR_SHIFT         = 2;

    // $clog2 clamped to at least one bit so single-entry counters stay legal
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Width of the y_buf word index (img * NUM_CLASS + class)
    function automatic int rbaw(input int img_num, input int num_class);
        return clog2_min1(img_num * num_class);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mlp_layer_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mlp_layer_sched_if
// Description : Bundles the scheduler's system start/done signals, the layer
//               datapath handshake, the score stream and the y_buf write port.
//               master : the scheduler side
//               slave  : the system / datapath / buffer side
// Ports       : none (signals only)
// Revision    : 1.0 - initial release
// ============================================================================
interface mlp_layer_sched_if
    import mlp_pkg::*;
#(
    parameter int IN_IMG_NUM       = IN_IMG_NUM_DEFAULT,
    parameter int NUM_LAYERS       = NUM_LAYERS_DEFAULT,
    parameter int Y_BUF_DATA_WIDTH = 32,
    parameter int Y_BUF_ADDR_WIDTH = 32
);
    localparam int LAYER_W = clog2_min1(NUM_LAYERS);
    localparam int IMG_W   = clog2_min1(IN_IMG_NUM);

    // system side
    logic                        start_i;
    logic                        busy_o;
    logic                        done_intr_o;
    logic                        done_led_o;
    // layer datapath
    logic                        layer_start_o;
    logic [LAYER_W-1:0]          layer_idx_o;
    logic [IMG_W-1:0]            img_idx_o;
    logic                        layer_done_i;
    // score stream
    logic                        score_valid_i;
    logic [Y_BUF_DATA_WIDTH-1:0] score_data_i;
    logic                        score_ready_o;
    // y_buf write port
    logic                        y_buf_en_o;
    logic                        y_buf_wr_en_o;
    logic [Y_BUF_ADDR_WIDTH-1:0] y_buf_addr_o;
    logic [Y_BUF_DATA_WIDTH-1:0] y_buf_data_o;

    modport master (
        input  start_i, layer_done_i, score_valid_i, score_data_i,
        output busy_o, done_intr_o, done_led_o, layer_start_o, layer_idx_o,
               img_idx_o, score_ready_o, y_buf_en_o, y_buf_wr_en_o,
               y_buf_addr_o, y_buf_data_o
    );

    modport slave (
        output start_i, layer_done_i, score_valid_i, score_data_i,
        input  busy_o, done_intr_o, done_led_o, layer_start_o, layer_idx_o,
               img_idx_o, score_ready_o, y_buf_en_o, y_buf_wr_en_o,
               y_buf_addr_o, y_buf_data_o
    );

endinterface
`default_nettype wire

// File: rtl/mlp_ybuf_writer.sv
`default_nettype none
// ============================================================================
// Module      : mlp_ybuf_writer
// Description : Turns an accepted score handshake into a single registered
//               y_buf write. The word index img*NUM_CLASS+class is converted
//               to a zero-extended byte address.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               wr_req         - score handshake this cycle
//               img, cls       - image / class counters at the handshake
//               score          - score data at the handshake
//               wr             - write strobe, valid the cycle after wr_req
//               addr, data     - registered byte address and write data
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_ybuf_writer
    import mlp_pkg::*;
#(
    parameter int IN_IMG_NUM = IN_IMG_NUM_DEFAULT,
    parameter int IMG_W      = 4,
    parameter int CLASS_W    = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               wr_req,
    input  wire logic [IMG_W-1:0]   img,
    input  wire logic [CLASS_W-1:0] cls,
    input  wire logic [DATA_W-1:0]  score,
    output logic                    wr,
    output logic [ADDR_W-1:0]       addr,
    output logic [DATA_W-1:0]       data
);
    localparam int RBAW = rbaw(IN_IMG_NUM, NUM_CLASS);

    logic [RBAW-1:0]   w_index;
    logic [ADDR_W-1:0] w_byte_addr;

    assign w_index     = RBAW'(img) * RBAW'(NUM_CLASS) + RBAW'(cls);
    assign w_byte_addr = ADDR_W'({w_index, {ADDR_SHIFT{1'b0}}});

    // Address and data only move on a handshake; a write in flight when
    // reset hits is discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr   <= 1'b0;
            addr <= '0;
            data <= '0;
        end else begin
            wr <= wr_req;
            if (wr_req) begin
                addr <= w_byte_addr;
                data <= score;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mlp_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : mlp_layer_sched
// Description : Sequencing controller for the MLP inference core. A start
//               walks every image through NUM_LAYERS layer launches, drains
//               NUM_CLASS scores per image into y_buf, then pulses the done
//               interrupt and sets the sticky done LED.
// Ports       : clk_i, rst_i - clock, synchronous active-high reset
//               bus          - mlp_layer_sched_if.master (start/done,
//                              layer launch, score stream, y_buf write)
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_layer_sched
    import mlp_pkg::*;
#(
    parameter int IN_IMG_NUM       = IN_IMG_NUM_DEFAULT,
    parameter int NUM_LAYERS       = NUM_LAYERS_DEFAULT,
    parameter int Y_BUF_DATA_WIDTH = 32,
    parameter int Y_BUF_ADDR_WIDTH = 32
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    mlp_layer_sched_if.master  bus
);
    localparam int LAYER_W = clog2_min1(NUM_LAYERS);
    localparam int IMG_W   = clog2_min1(IN_IMG_NUM);
    localparam int CLASS_W = clog2_min1(NUM_CLASS);

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [IMG_W-1:0]   LAST_IMG   = IMG_W'(IN_IMG_NUM - 1);
    localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASS - 1);

    sched_state_t         r_state;
    logic [LAYER_W-1:0]   r_layer;
    logic [IMG_W-1:0]     r_img;
    logic [CLASS_W-1:0]   r_class;
    logic                 r_busy;
    logic                 r_layer_start;
    logic                 r_done_intr;
    logic                 r_done_led;
    logic                 r_score_ready;

    logic                        w_score_hs;
    logic                        w_wr;
    logic [Y_BUF_ADDR_WIDTH-1:0] w_addr;
    logic [Y_BUF_DATA_WIDTH-1:0] w_data;

    // ready is only ever high in DRAIN, so a handshake implies DRAIN
    assign w_score_hs = bus.score_valid_i & r_score_ready;

    // Outputs are registered alongside the state so each one reflects the
    // state being entered, not the one being left.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_layer       <= '0;
            r_img         <= '0;
            r_class       <= '0;
            r_busy        <= 1'b0;
            r_layer_start <= 1'b0;
            r_done_intr   <= 1'b0;
            r_done_led    <= 1'b0;
            r_score_ready <= 1'b0;
        end else begin
            r_layer_start <= 1'b0;
            r_done_intr   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        r_state       <= ST_LAUNCH;
                        r_busy        <= 1'b1;
                        r_layer_start <= 1'b1;
                        r_layer       <= '0;
                        r_img         <= '0;
                        r_class       <= '0;
                        r_done_led    <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    r_state <= ST_WAIT_LAYER;
                end
                ST_WAIT_LAYER: begin
                    if (bus.layer_done_i) begin
                        if (r_layer != LAST_LAYER) begin
                            r_layer       <= r_layer + LAYER_W'(1);
                            r_layer_start <= 1'b1;
                            r_state       <= ST_LAUNCH;
                        end else begin
                            r_class       <= '0;
                            r_score_ready <= 1'b1;
                            r_state       <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_score_hs) begin
                        if (r_class == LAST_CLASS) begin
                            r_score_ready <= 1'b0;
                            r_state       <= ST_NEXT_IMG;
                        end else begin
                            r_class <= r_class + CLASS_W'(1);
                        end
                    end
                end
                ST_NEXT_IMG: begin
                    if (r_img == LAST_IMG) begin
                        r_state     <= ST_DONE;
                        r_done_intr <= 1'b1;
                        r_done_led  <= 1'b1;
                    end else begin
                        r_img         <= r_img + IMG_W'(1);
                        r_layer       <= '0;
                        r_layer_start <= 1'b1;
                        r_state       <= ST_LAUNCH;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy        <= 1'b0;
                    r_score_ready <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    mlp_ybuf_writer #(
        .IN_IMG_NUM (IN_IMG_NUM),
        .IMG_W      (IMG_W),
        .CLASS_W    (CLASS_W),
        .DATA_W     (Y_BUF_DATA_WIDTH),
        .ADDR_W     (Y_BUF_ADDR_WIDTH)
    ) u_ybuf_writer (
        .clk    (clk_i),
        .rst    (rst_i),
        .wr_req (w_score_hs),
        .img    (r_img),
        .cls    (r_class),
        .score  (bus.score_data_i),
        .wr     (w_wr),
        .addr   (w_addr),
        .data   (w_data)
    );

    assign bus.busy_o        = r_busy;
    assign bus.done_intr_o   = r_done_intr;
    assign bus.done_led_o    = r_done_led;
    assign bus.layer_start_o = r_layer_start;
    assign bus.layer_idx_o   = r_layer;
    assign bus.img_idx_o     = r_img;
    assign bus.score_ready_o = r_score_ready;
    assign bus.y_buf_en_o    = w_wr;
    assign bus.y_buf_wr_en_o = w_wr;
    assign bus.y_buf_addr_o  = w_addr;
    assign bus.y_buf_data_o  = w_data;

endmodule
`default_nettype wire

// File: tb/tb_mlp_layer_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_layer_sched
// Description : Self-checking bench for mlp_layer_sched. A small datapath and
//               score-producer model drives the DUT; every accepted score
//               handshake pushes the expected y_buf write onto a queue that is
//               popped when the DUT writes. A table of run configurations
//               covers stream patterns, spurious inputs and held start; hand
//               sequences cover mid-drain reset and back-to-back runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_layer_sched;
    import mlp_pkg::*;

    localparam int IMG    = 10;
    localparam int NL     = 3;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int TOTAL  = IMG * NUM_CLASS;
    localparam int BUDGET = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mlp_layer_sched_if #(
        .IN_IMG_NUM(IMG), .NUM_LAYERS(NL),
        .Y_BUF_DATA_WIDTH(DW), .Y_BUF_ADDR_WIDTH(AW)
    ) bus ();

    mlp_layer_sched #(
        .IN_IMG_NUM(IMG), .NUM_LAYERS(NL),
        .Y_BUF_DATA_WIDTH(DW), .Y_BUF_ADDR_WIDTH(AW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        int            vmode;      // 0: valid always high, 1: 1,0,0,1 pattern
        bit            spur;       // inject spurious layer_done / valid
        bit            hold;       // hold start_i high during the run
        int            exp_launch;
        int            exp_write;
        logic [AW-1:0] exp_last;
    } run_vec_t;

    wr_t exp_q[$];
    wr_t trace[$];
    int  checks = 0;
    int  errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] score_val(input int idx);
        return DW'(100 + idx);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   64'(bus.busy_o), 0);
        check({tag, "_lstart"}, 64'(bus.layer_start_o), 0);
        check({tag, "_intr"},   64'(bus.done_intr_o), 0);
        check({tag, "_led"},    64'(bus.done_led_o), 0);
        check({tag, "_ready"},  64'(bus.score_ready_o), 0);
        check({tag, "_en"},     64'({bus.y_buf_en_o, bus.y_buf_wr_en_o}), 0);
        check({tag, "_addr"},   64'(bus.y_buf_addr_o), 0);
        check({tag, "_data"},   64'(bus.y_buf_data_o), 0);
        check({tag, "_idx"},    64'({bus.layer_idx_o, bus.img_idx_o}), 0);
    endtask

    // One full start-to-done run; called at a sample point with the DUT idle.
    // abort_at > 0 asserts reset once that many writes have been seen.
    task automatic do_run(input int vmode, input bit spur, input bit hold,
                          input int abort_at, input bit rec, input bit cmp,
                          output int n_launch, output int n_write,
                          output logic [AW-1:0] last_addr);
        int  cyc = 0, countdown = -1, prod = 0, wcnt = 0, drain_cyc = 0;
        int  last_hs_cyc = -1, done_cyc = 0;
        bit  prev_ready = 0, prev_valid = 0, prev_lstart = 0;
        bit  expect_adv = 0, spur_chk = 0, done_seen = 0, finished = 0;
        bit  hs, vld, ld;
        wr_t e;
        n_launch = 0; n_write = 0; last_addr = '0;
        exp_q.delete();

        bus.start_i = 1'b1;
        step();
        check("start_busy", 64'(bus.busy_o), 1);
        check("start_led_clear", 64'(bus.done_led_o), 0);
        if (!hold) bus.start_i = 1'b0;

        while (1) begin
            // ---- sample phase ----
            hs = prev_ready && prev_valid;
            if (hs) begin
                exp_q.push_back('{addr: AW'(prod * 4), data: score_val(prod)});
                prod++;
                check("write_latency", 64'(bus.y_buf_en_o), 1);
                if (prod == TOTAL) last_hs_cyc = cyc;
            end
            if (bus.y_buf_en_o) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: addr %0d data %0d, expected no write",
                             bus.y_buf_addr_o, bus.y_buf_data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(bus.y_buf_addr_o), 64'(e.addr));
                    check("wr_data", 64'(bus.y_buf_data_o), 64'(e.data));
                    check("wr_en_pair", 64'(bus.y_buf_wr_en_o), 1);
                    if (cmp && wcnt < trace.size()) begin
                        check("trace_addr", 64'(bus.y_buf_addr_o), 64'(trace[wcnt].addr));
                        check("trace_data", 64'(bus.y_buf_data_o), 64'(trace[wcnt].data));
                    end
                    if (rec) trace.push_back(e);
                    last_addr = bus.y_buf_addr_o;
                    wcnt++; n_write++;
                    if (abort_at > 0 && wcnt == abort_at) begin
                        rst = 1'b1;
                        bus.start_i = 1'b0; bus.score_valid_i = 1'b0; bus.layer_done_i = 1'b0;
                        step();
                        check_all_zero("reset_mid_drain");
                        rst = 1'b0;
                        return;
                    end
                end
            end
            if (expect_adv) begin
                check("layer_done_response", 64'(bus.layer_start_o | bus.score_ready_o), 1);
                expect_adv = 0;
            end
            if (spur_chk) begin
                check("spur_launch_ignored",
                      64'({bus.busy_o, bus.layer_start_o, bus.score_ready_o}), 64'(3'b100));
                spur_chk = 0;
            end
            if (bus.layer_start_o) begin
                check("lstart_single", 64'(prev_lstart), 0);
                check("layer_idx", 64'(bus.layer_idx_o), 64'(n_launch % NL));
                check("img_idx", 64'(bus.img_idx_o), 64'(n_launch / NL));
                n_launch++;
                countdown = 5;
            end
            if (bus.done_intr_o) begin
                check("done_once", 64'(done_seen), 0);
                check("done_latency", 64'(cyc), 64'(last_hs_cyc + 1));
                check("done_led_set", 64'(bus.done_led_o), 1);
                check("done_exp_q_empty", 64'(exp_q.size()), 0);
                done_seen = 1; done_cyc = cyc;
                bus.start_i = 1'b0;
            end
            if (done_seen && cyc == done_cyc + 1) begin
                check("idle_after_done", 64'(bus.busy_o), 0);
                check("intr_one_cycle", 64'(bus.done_intr_o), 0);
                check("led_sticky", 64'(bus.done_led_o), 1);
                finished = 1;
            end
            prev_lstart = bus.layer_start_o;
            if (finished) break;

            // ---- drive phase ----
            ld = 1'b0;
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    ld = 1'b1; expect_adv = 1; countdown = -1;
                end
            end
            if (spur && bus.layer_start_o) begin
                ld = 1'b1; spur_chk = 1;
            end
            vld = 1'b0;
            if (bus.score_ready_o && prod < TOTAL) begin
                vld = (vmode == 0) || (drain_cyc % 4 == 0) || (drain_cyc % 4 == 3);
                if (spur && drain_cyc == 2) ld = 1'b1;
                drain_cyc++;
            end else begin
                drain_cyc = 0;
                if (spur && bus.busy_o) vld = 1'b1;
            end
            prev_ready        = bus.score_ready_o;
            prev_valid        = vld;
            bus.score_valid_i = vld;
            bus.score_data_i  = score_val(prod);
            bus.layer_done_i  = ld;
            cyc++;
            if (cyc > BUDGET) begin
                checks++; errors++;
                $display("FAIL run_timeout: no completion after %0d cycles, expected done", BUDGET);
                break;
            end
            step();
        end
        bus.score_valid_i = 1'b0;
        bus.layer_done_i  = 1'b0;
        bus.start_i       = 1'b0;
    endtask

    run_vec_t vecs[4];
    int nl, nw;
    logic [AW-1:0] la;

    initial begin
        bus.start_i = 1'b0; bus.layer_done_i = 1'b0;
        bus.score_valid_i = 1'b0; bus.score_data_i = '0;
        rst = 1'b1;
        repeat (3) step();
        check_all_zero("reset");
        rst = 1'b0;
        step();
        check_all_zero("post_reset_idle");

        vecs[0] = '{vmode: 0, spur: 0, hold: 0, exp_launch: 30, exp_write: 100, exp_last: 396};
        vecs[1] = '{vmode: 1, spur: 0, hold: 1, exp_launch: 30, exp_write: 100, exp_last: 396};
        vecs[2] = '{vmode: 0, spur: 1, hold: 0, exp_launch: 30, exp_write: 100, exp_last: 396};
        vecs[3] = '{vmode: 1, spur: 1, hold: 1, exp_launch: 30, exp_write: 100, exp_last: 396};

        for (int i = 0; i < 4; i++) begin
            do_run(vecs[i].vmode, vecs[i].spur, vecs[i].hold, 0, (i == 0), 0, nl, nw, la);
            check("launch_count", 64'(nl), 64'(vecs[i].exp_launch));
            check("write_count", 64'(nw), 64'(vecs[i].exp_write));
            check("last_addr", 64'(la), 64'(vecs[i].exp_last));
            check("last_img_idx", 64'(bus.img_idx_o), 64'(IMG - 1));
            repeat (3) begin
                step();
                check("idle_hold", 64'({bus.busy_o, bus.layer_start_o, bus.y_buf_en_o}), 0);
                check("idle_led", 64'(bus.done_led_o), 1);
            end
        end

        // reset in the middle of the first image's drain
        do_run(0, 0, 0, 4, 0, 0, nl, nw, la);
        check("abort_writes", 64'(nw), 4);
        repeat (2) begin
            step();
            check("abort_stays_idle", 64'({bus.busy_o, bus.layer_start_o, bus.y_buf_en_o}), 0);
        end

        // fresh run after reset, then an immediate restart at the earliest slot
        do_run(1, 0, 0, 0, 0, 1, nl, nw, la);
        check("b2b_first_writes", 64'(nw), 100);
        check("b2b_led_before", 64'(bus.done_led_o), 1);
        do_run(0, 0, 0, 0, 0, 1, nl, nw, la);
        check("b2b_second_writes", 64'(nw), 100);
        check("b2b_second_last", 64'(la), 396);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mlp_layer_sched.md
# mlp_layer_sched

Sequencing controller for the MLP inference core. On a start request it walks every input image through each layer of the datapath, one layer launch at a time. It drains the 10 class scores per image into the output buffer at byte addresses, then raises the done interrupt and LED. It sits between the system start/done interface and the layer datapath / y_buf write port, in place of the ad-hoc sequencing inside the core top.

## Interface
- IN_IMG_NUM, 10, images processed per start
- NUM_LAYERS, 3, layer launches per image
- NUM_CLASS, 10, scores written per image
- Y_BUF_DATA_WIDTH, 32, score / y_buf data width
- Y_BUF_ADDR_WIDTH, 32, byte-address width of y_buf port
- clk_i  in  1  single clock, all logic rising-edge
- rst_i  in  1  synchronous, active-high reset
- start_i  in  1  level or pulse; sampled only in IDLE
- busy_o  out  1  high in every state except IDLE
- done_intr_o  out  1  one-cycle pulse at end of run
- done_led_o  out  1  sticky; set at end of run, cleared by next accepted start or reset
- layer_start_o  out  1  one-cycle launch pulse to datapath
- layer_idx_o  out  $clog2(NUM_LAYERS)  layer being run, stable from launch to done
- img_idx_o  out  $clog2(IN_IMG_NUM)  image being run
- layer_done_i  in  1  one-cycle completion pulse from datapath
- score_valid_i  in  1  score stream valid
- score_data_i  in  Y_BUF_DATA_WIDTH  score value
- score_ready_o  out  1  score stream ready
- y_buf_en_o, y_buf_wr_en_o  out  1 each  write strobe, both asserted together
- y_buf_addr_o  out  Y_BUF_ADDR_WIDTH  byte address
- y_buf_data_o  out  Y_BUF_DATA_WIDTH  write data

## Operation
- States: IDLE, LAUNCH, WAIT_LAYER, DRAIN, NEXT_IMG, DONE.
- IDLE: start_i=1 -> LAUNCH. Clears img, layer, class counters and done_led_o.
- LAUNCH: layer_start_o=1 for exactly this cycle -> WAIT_LAYER.
- WAIT_LAYER: on layer_done_i, if layer<NUM_LAYERS-1 then layer++ and go to LAUNCH; otherwise class=0 and go to DRAIN.
- DRAIN: score_ready_o=1. Each score_valid_i&score_ready_o handshake registers a write and increments class. The handshake with class==NUM_CLASS-1 -> NEXT_IMG.
- NEXT_IMG: if img==IN_IMG_NUM-1 -> DONE; otherwise img++, layer=0 -> LAUNCH.
- DONE: done_intr_o=1 and done_led_o set -> IDLE.
- Word index = img*NUM_CLASS+class, width RBAW=$clog2(IN_IMG_NUM*NUM_CLASS).
- y_buf_addr_o = zero-extended {index, 2'b00}. Default range is 0..396, step 4, no wrap.
- Ignored inputs, with no side effects:
  - start_i while busy
  - layer_done_i outside WAIT_LAYER
  - score_valid_i outside DRAIN (ready is low there, so the producer holds its data)
- Reset in any state: IDLE within one cycle, counters zero, pending y_buf write dropped.

## Timing
- Reset values: all outputs 0, including done_led_o, y_buf_addr_o and y_buf_data_o.
- Start sampled at edge N -> layer_start_o high in cycle N+1 (busy_o high from N+1).
- layer_done_i at edge M -> next layer_start_o at cycle M+1 (via LAUNCH), or score_ready_o high from M+1.
- Score handshake at edge T -> y_buf strobe, address and data registered, valid in cycle T+1 for one cycle. Back-to-back handshakes give back-to-back writes.
- The last handshake of the run is at T:
  - last write in T+1
  - NEXT_IMG in T+1
  - DONE and done_intr_o in T+2
  - IDLE in T+3
- Earliest re-start is sampled at T+3.
- layer_start_o, done_intr_o and y_buf strobes are never high for more than one consecutive cycle, except strobes during consecutive handshakes.

## Structure
- Shared package mlp_pkg: state enum, NUM_CLASS, default IN_IMG_NUM, RBAW function, and the byte-address shift constant (2).
- One natural sub-module, mlp_ybuf_writer: handshake-to-registered-write stage plus word-to-byte address formation.
- The FSM and counters stay in the parent.

## Test plan
- Single run, IN_IMG_NUM=1. Datapath returns layer_done_i 5 cycles after each launch, scores 100..109 with valid held high -> 3 launch pulses, then 10 writes at addresses 0,4,..,36 with data 100..109, then one done_intr_o pulse 2 cycles after the last handshake, and done_led_o stays 1.
- Full default run -> 30 launches, 100 writes. The last write is at address 396 with img_idx_o=9. start_i held high throughout is ignored until IDLE.
- Stalled stream in DRAIN: valid toggles 1,0,0,1 -> writes only on valid cycles, addresses contiguous, no duplicates.
- Spurious inputs: layer_done_i during LAUNCH or DRAIN and score_valid_i during WAIT_LAYER -> no state change, no write.
- rst_i asserted mid-DRAIN after 4 writes -> next cycle all outputs 0 and IDLE. A new start restarts at address 0 and clears done_led_o.
- Back-to-back runs: start at T+3 after the first run -> done_led_o cleared in the start cycle+1, and the second run matches the first run's write trace.
